// File: rtl/rs232_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs232_pkg                                                    |
// | Description : Shared constants and types for the RS-232 receive/transmit   |
// |               pair: default oversampling ratio, stop-bit and parity        |
// |               encodings, and the transmitter state enumeration.            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rs232_pkg;

  // Bit-clock cycles per serial bit; rs232_rx and rs232_tx must agree.
  localparam int DEFAULT_OSR = 9;

  // Stop-bit count encodings.
  localparam int STOP_BITS_ONE = 1;
  localparam int STOP_BITS_TWO = 2;

  // Parity sense encodings (only meaningful when parity is enabled).
  localparam int PAR_SEL_EVEN = 0;
  localparam int PAR_SEL_ODD  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_e;

  // Counter width large enough for a two-stop-bit period (2*OSR-1).
  function automatic int timer_width(input int osr);
    return $clog2(2 * osr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs232_tx_if                                                  |
// | Description : FIFO read-side bundle between the byte FIFO and rs232_tx.    |
// | Signals     : empty  - FIFO empty flag              (FIFO -> tx)           |
// |               din    - read data, valid cycle after rd_en (FIFO -> tx)     |
// |               rd_en  - one-cycle read strobe        (tx -> FIFO)           |
// |               rd_clk - FIFO read clock, equals tx bit clock (tx -> FIFO)   |
// | Modports    : master - transmitter side; slave - FIFO side                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rs232_tx_if;
  logic       empty;
  logic [7:0] din;
  logic       rd_en;
  logic       rd_clk;

  modport master (
    input  empty,
    input  din,
    output rd_en,
    output rd_clk
  );

  modport slave (
    input  rd_en,
    input  rd_clk,
    output empty,
    output din
  );
endinterface
`default_nettype wire

// File: rtl/rs232_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs232_bit_timer                                              |
// | Description : Per-bit cycle counter with a programmable terminal count.    |
// |               Counts 0..tc, wraps to 0 after tc, and restarts at 0         |
// |               whenever clr is asserted.                                    |
// | Ports       : clk      in  clock                                           |
// |               rst      in  synchronous active-high reset                   |
// |               clr      in  restart the count (owner's state change)        |
// |               tc       in  terminal count (period - 1)                     |
// |               bit_done out high during the last cycle of the period        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rs232_bit_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] tc,
  output logic          bit_done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done = (cnt_q == tc);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    // Wrap at the terminal count so consecutive bits in one state
    // (the data bits) each get a full period without a state change.
    if (clr || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs232_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs232_tx                                                     |
// | Description : UART transmitter. Pulls one byte per frame from a standard   |
// |               (non-show-ahead) FIFO and serialises it LSB first with a     |
// |               start bit, optional parity bit and 1 or 2 stop bits.         |
// | Parameters  : OSR        bit-clock cycles per serial bit                   |
// |               PARITY_EN  1 inserts a parity bit after D7                   |
// |               PARITY_ODD 0 even parity, 1 odd parity                       |
// |               STOP_BITS  1 or 2                                            |
// | Ports       : clk_tx  in  bit clock (also the FIFO read clock)             |
// |               rst     in  synchronous active-high reset                    |
// |               fifo    master modport of rs232_tx_if (empty/din/rd_en/      |
// |                       rd_clk)                                              |
// |               tx      out serial line, registered, idle high               |
// |               busy    out high from FETCH through the last STOP cycle      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int OSR        = DEFAULT_OSR,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = PAR_SEL_EVEN,
  parameter int STOP_BITS  = STOP_BITS_ONE
) (
  input  logic       clk_tx,
  input  logic       rst,
  rs232_tx_if.master fifo,
  output logic       tx,
  output logic       busy
);

  localparam int            CW          = timer_width(OSR);
  localparam logic [CW-1:0] TC_BIT      = CW'(OSR - 1);
  localparam logic [CW-1:0] TC_STOP     = CW'(STOP_BITS * OSR - 1);
  localparam logic          PAR_EN_BIT  = (PARITY_EN != 0);
  localparam logic          PAR_ODD_BIT = (PARITY_ODD != 0);

  tx_state_e   state_q, state_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;

  logic          rd_en_w;
  logic [CW-1:0] tc_w;
  logic          clr_w;
  logic          bit_done_w;

  // The counter restarts on every state transition, so each state's
  // period is measured from its own first cycle.
  assign clr_w = (state_d != state_q);

  rs232_bit_timer #(
    .CW (CW)
  ) u_bit_timer (
    .clk      (clk_tx),
    .rst      (rst),
    .clr      (clr_w),
    .tc       (tc_w),
    .bit_done (bit_done_w)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    rd_en_w = 1'b0;
    tc_w    = TC_BIT;

    case (state_q)
      ST_IDLE: begin
        if (!fifo.empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_en_w = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // din is valid now, one cycle after the read strobe.
        sh_d    = fifo.din;
        par_d   = (^fifo.din) ^ PAR_ODD_BIT;
        idx_d   = 3'd0;
        state_d = ST_START;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done_w) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = sh_q[idx_q];
        if (bit_done_w) begin
          if (idx_q == 3'd7) begin
            state_d = PAR_EN_BIT ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_done_w) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        tc_w = TC_STOP;
        if (bit_done_w) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx follows the state by one cycle; registering it keeps the line
  // free of decode glitches.
  always_ff @(posedge clk_tx) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= 8'h00;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE);
  assign fifo.rd_en  = rd_en_w;
  assign fifo.rd_clk = clk_tx;

endmodule
`default_nettype wire

// File: tb/tb_rs232_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rs232_tx                                                  |
// | Description : Directed self-checking bench for rs232_tx. Three instances:  |
// |               dut 0 defaults, dut 1 even parity, dut 2 odd parity with     |
// |               two stop bits. Each has a small behavioural FIFO.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rs232_tx;

  localparam int OSR = 9;
  localparam logic [31:0] BIT_ONES = (32'h1 << OSR) - 32'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs232_tx_if ifc_a ();
  rs232_tx_if ifc_b ();
  rs232_tx_if ifc_c ();

  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] rd_v;
  logic [2:0] empty_r = 3'b111;
  logic [7:0] din_r [3] = '{8'h00, 8'h00, 8'h00};

  assign ifc_a.empty = empty_r[0];
  assign ifc_b.empty = empty_r[1];
  assign ifc_c.empty = empty_r[2];
  assign ifc_a.din   = din_r[0];
  assign ifc_b.din   = din_r[1];
  assign ifc_c.din   = din_r[2];
  assign rd_v[0]     = ifc_a.rd_en;
  assign rd_v[1]     = ifc_b.rd_en;
  assign rd_v[2]     = ifc_c.rd_en;

  rs232_tx #(.OSR(OSR)) dut_a (
    .clk_tx (clk), .rst (rst), .fifo (ifc_a), .tx (tx_v[0]), .busy (busy_v[0])
  );
  rs232_tx #(.OSR(OSR), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk_tx (clk), .rst (rst), .fifo (ifc_b), .tx (tx_v[1]), .busy (busy_v[1])
  );
  rs232_tx #(.OSR(OSR), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_c (
    .clk_tx (clk), .rst (rst), .fifo (ifc_c), .tx (tx_v[2]), .busy (busy_v[2])
  );

  int errors = 0;
  int checks = 0;
  int rd_cnt [3] = '{0, 0, 0};
  int underflow = 0;
  int idle_viol = 0;
  bit mon_en = 1'b0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int start_cyc = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  // Behavioural FIFO read side: data appears the cycle after rd_en.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rd_v[i]) rd_cnt[i]++;
    end
    if (rd_v[0]) begin if (q0.size() == 0) underflow++; else din_r[0] <= q0.pop_front(); end
    if (rd_v[1]) begin if (q1.size() == 0) underflow++; else din_r[1] <= q1.pop_front(); end
    if (rd_v[2]) begin if (q2.size() == 0) underflow++; else din_r[2] <= q2.pop_front(); end
  end

  always @(negedge clk) begin
    empty_r[0] = (q0.size() == 0);
    empty_r[1] = (q1.size() == 0);
    empty_r[2] = (q2.size() == 0);
    if (rd_v[0]) last_rd_cyc = cyc;
    if (mon_en && (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rd_v[0] !== 1'b0))
      idle_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    case (d)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic grab(input int d, input int n, output logic [31:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      v[k] = tx_v[d];
    end
  endtask

  // Waits for the start bit, then checks every cycle of every bit.
  task automatic frame_chk(input int d, input logic [7:0] b, input logic has_par,
                           input logic pb, input int nstop, input bit gap_chk);
    int waited;
    logic [31:0] v;
    waited = 0;
    @(negedge clk);
    while (tx_v[d] !== 1'b0 && waited < 2000) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 2000) begin
      check_eq($sformatf("dut%0d_start_seen", d), 32'(tx_v[d]), 32'h0);
      return;
    end
    start_cyc = cyc;
    if (gap_chk) check_eq($sformatf("dut%0d_gap", d), 32'(waited), 32'd3);
    check_eq($sformatf("dut%0d_busy_start", d), 32'(busy_v[d]), 32'h1);
    grab(d, OSR - 1, v);
    check_eq($sformatf("dut%0d_start_%02h", d, b), v, 32'h0);
    for (int j = 0; j < 8; j++) begin
      grab(d, OSR, v);
      check_eq($sformatf("dut%0d_d%0d_%02h", d, j, b), v, b[j] ? BIT_ONES : 32'h0);
    end
    if (has_par) begin
      grab(d, OSR, v);
      check_eq($sformatf("dut%0d_par_%02h", d, b), v, pb ? BIT_ONES : 32'h0);
    end
    grab(d, nstop, v);
    check_eq($sformatf("dut%0d_stop_%02h", d, b), v, (32'h1 << nstop) - 32'h1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_a",   32'(tx_v[0]),   32'h1);
    check_eq("rst_busy_a", 32'(busy_v[0]), 32'h0);
    check_eq("rst_rd_a",   32'(rd_v[0]),   32'h0);
    check_eq("rst_tx_c",   32'(tx_v[2]),   32'h1);
    @(posedge clk); #1 rst = 1'b0;

    // Empty FIFO: line stays idle.
    mon_en = 1'b1;
    repeat (200) @(negedge clk);
    mon_en = 1'b0;
    check_eq("idle_viol", 32'(idle_viol), 32'h0);
    check_eq("idle_rd_cnt", 32'(rd_cnt[0]), 32'h0);

    // Single 0x55 with defaults.
    @(posedge clk); #1 push(0, 8'h55);
    frame_chk(0, 8'h55, 1'b0, 1'b0, OSR, 1'b0);
    check_eq("latency_rd_to_start", 32'(start_cyc - last_rd_cyc), 32'd3);
    check_eq("rd_cnt_55", 32'(rd_cnt[0]), 32'd1);
    repeat (20) @(negedge clk);
    check_eq("post_tx", 32'(tx_v[0]), 32'h1);
    check_eq("post_busy", 32'(busy_v[0]), 32'h0);
    check_eq("post_rd_cnt", 32'(rd_cnt[0]), 32'd1);

    // Parity on 0xA3 (four ones): even -> 0, odd -> 1.
    @(posedge clk); #1 push(1, 8'hA3);
    frame_chk(1, 8'hA3, 1'b1, 1'b0, OSR, 1'b0);
    check_eq("rd_cnt_b", 32'(rd_cnt[1]), 32'd1);
    @(posedge clk); #1 push(2, 8'hA3);
    frame_chk(2, 8'hA3, 1'b1, 1'b1, 2 * OSR, 1'b0);

    // Back-to-back 0x00 / 0xFF with two stop bits and odd parity.
    @(posedge clk); #1 push(2, 8'h00); push(2, 8'hFF);
    frame_chk(2, 8'h00, 1'b1, 1'b1, 2 * OSR, 1'b0);
    frame_chk(2, 8'hFF, 1'b1, 1'b1, 2 * OSR, 1'b1);
    check_eq("rd_cnt_c", 32'(rd_cnt[2]), 32'd3);

    // Reset during data bit 3 of 0x3C.
    @(posedge clk); #1 push(0, 8'h3C);
    waited = 0;
    @(negedge clk);
    while (tx_v[0] !== 1'b0 && waited < 200) begin waited++; @(negedge clk); end
    check_eq("abort_start_seen", 32'(tx_v[0]), 32'h0);
    repeat (40) @(negedge clk);
    check_eq("abort_bit3", 32'(tx_v[0]), 32'h1);
    check_eq("abort_busy_before", 32'(busy_v[0]), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_tx", 32'(tx_v[0]), 32'h1);
    check_eq("abort_busy", 32'(busy_v[0]), 32'h0);
    rst = 1'b0;
    idle_viol = 0;
    mon_en = 1'b1;
    repeat (60) @(negedge clk);
    mon_en = 1'b0;
    check_eq("abort_idle_viol", 32'(idle_viol), 32'h0);
    check_eq("abort_rd_cnt", 32'(rd_cnt[0]), 32'd2);

    // Reset held while the FIFO is non-empty: no read until release.
    rst = 1'b1;
    @(posedge clk); #1 push(0, 8'h55);
    repeat (6) @(negedge clk);
    check_eq("rst_hold_rd_cnt", 32'(rd_cnt[0]), 32'd2);
    check_eq("rst_hold_busy", 32'(busy_v[0]), 32'h0);
    rst = 1'b0;
    frame_chk(0, 8'h55, 1'b0, 1'b0, OSR, 1'b0);
    check_eq("rst_release_rd_cnt", 32'(rd_cnt[0]), 32'd3);

    // Every byte value, back to back, decoded from the line.
    @(posedge clk); #1;
    for (int k = 0; k < 256; k++) push(0, 8'(k));
    for (int k = 0; k < 256; k++) frame_chk(0, 8'(k), 1'b0, 1'b0, OSR, k > 0);
    check_eq("all_bytes_rd_cnt", 32'(rd_cnt[0]), 32'd259);
    check_eq("underflow", 32'(underflow), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
